// File: rtl/adder_accum.sv
// Frame accumulator: sums NUM_OPS unsigned words into a BW_ACC-bit total with
// a sticky wrap flag, then holds the total on a valid/ready port until taken.
module adder_accum #(
   parameter int BW_DATA = 8,
   parameter int NUM_OPS = 4,
   parameter int BW_ACC  = 10,
   parameter int BW_CNT  = 2
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_clr,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [BW_DATA-1:0] i_data,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [BW_ACC-1:0]  o_acc,
   output logic               o_ovf,
   output logic [BW_CNT-1:0]  o_cnt
);

   if ((2 ** BW_CNT) < NUM_OPS) begin : g_bad_cnt_width
      $error("adder_accum: BW_CNT too narrow to count NUM_OPS words");
   end
   if (NUM_OPS < 2) begin : g_bad_num_ops
      $error("adder_accum: NUM_OPS must be at least 2");
   end
   if (BW_ACC < BW_DATA) begin : g_bad_acc_width
      $error("adder_accum: BW_ACC must be at least BW_DATA");
   end

   localparam logic [BW_CNT-1:0] LAST_CNT = BW_CNT'(NUM_OPS - 1);

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t              state, state_nxt;
   logic [BW_ACC-1:0]   acc, acc_nxt;
   logic [BW_CNT-1:0]   cnt, cnt_nxt;
   logic                ovf, ovf_nxt;
   logic [BW_ACC:0]     sum;
   logic                accept;

   // Widened add: the extra MSB is the carry that feeds the sticky wrap flag.
   function automatic logic [BW_ACC:0] acc_add(input logic [BW_ACC-1:0]  a,
                                                input logic [BW_DATA-1:0] d);
      return {1'b0, a} + (BW_ACC + 1)'(d);
   endfunction

   assign o_ready = (state == ST_ACC) && !i_rst;
   assign o_valid = (state == ST_HOLD);
   assign o_acc   = acc;
   assign o_ovf   = ovf;
   assign o_cnt   = cnt;
   assign accept  = i_valid && o_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= ST_ACC;
         acc   <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
         ovf   <= ovf_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      ovf_nxt   = ovf;
      sum       = acc_add(acc, i_data);
      unique case (state)
         ST_ACC: begin
            // Clear wins over a word offered in the same cycle.
            if (i_clr) begin
               acc_nxt = '0;
               cnt_nxt = '0;
               ovf_nxt = 1'b0;
            end else if (accept) begin
               acc_nxt = sum[BW_ACC-1:0];
               ovf_nxt = ovf | sum[BW_ACC];
               if (cnt == LAST_CNT) begin
                  cnt_nxt   = '0;
                  state_nxt = ST_HOLD;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (i_clr || i_ready) begin
               acc_nxt   = '0;
               ovf_nxt   = 1'b0;
               state_nxt = ST_ACC;
            end
         end
         default: state_nxt = ST_ACC;
      endcase
   end

endmodule

// File: tb/tb_adder_accum.sv
// Directed bench for adder_accum: a default instance and a BW_ACC=8 instance
// share stimulus and are checked every cycle against an integer frame model.
module tb_adder_accum;

   localparam int NUM_OPS = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0, clr = 1'b0, vld = 1'b0, rdy = 1'b0;
   logic [7:0] data = '0;

   logic       rdy_a, val_a, ovf_a, rdy_b, val_b, ovf_b;
   logic [9:0] acc_a;
   logic [7:0] acc_b;
   logic [1:0] cnt_a, cnt_b;

   int vectors = 0;
   int miscompares = 0;

   adder_accum dut_a (
      .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_valid(vld), .o_ready(rdy_a),
      .i_data(data), .o_valid(val_a), .i_ready(rdy), .o_acc(acc_a),
      .o_ovf(ovf_a), .o_cnt(cnt_a)
   );

   adder_accum #(.BW_ACC(8)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_valid(vld), .o_ready(rdy_b),
      .i_data(data), .o_valid(val_b), .i_ready(rdy), .o_acc(acc_b),
      .o_ovf(ovf_b), .o_cnt(cnt_b)
   );

   always #5 clk = ~clk;

   // Model: unbounded integer frame total and word count; widths applied on compare.
   int tot = 0;
   int n = 0;
   bit armed = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         tot = 0; n = 0; armed = 1'b1;
      end else if (n == NUM_OPS) begin
         if (clr || rdy) begin tot = 0; n = 0; end
      end else if (clr) begin
         tot = 0; n = 0;
      end else if (vld) begin
         tot = tot + int'(data); n = n + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (armed) begin
         chk("a.valid", 32'(val_a), 32'(n == NUM_OPS));
         chk("a.ready", 32'(rdy_a), 32'(n != NUM_OPS && !rst));
         chk("a.acc",   32'(acc_a), 32'(tot % 1024));
         chk("a.ovf",   32'(ovf_a), 32'(tot >= 1024));
         chk("a.cnt",   32'(cnt_a), 32'((n == NUM_OPS) ? 0 : n));
         chk("b.valid", 32'(val_b), 32'(n == NUM_OPS));
         chk("b.ready", 32'(rdy_b), 32'(n != NUM_OPS && !rst));
         chk("b.acc",   32'(acc_b), 32'(tot % 256));
         chk("b.ovf",   32'(ovf_b), 32'(tot >= 256));
         chk("b.cnt",   32'(cnt_b), 32'((n == NUM_OPS) ? 0 : n));
      end
   end

   task automatic tick(input logic r, input logic c, input logic v,
                       input logic [7:0] d, input logic k);
      rst = r; clr = c; vld = v; data = d; rdy = k;
      @(posedge clk);
      #1;
   endtask

   task automatic frame4(input logic [7:0] w0, w1, w2, w3);
      tick(0, 0, 1, w0, 0);
      tick(0, 0, 1, w1, 0);
      tick(0, 0, 1, w2, 0);
      tick(0, 0, 1, w3, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   totals[2];
      int   ntot;
      int   k;
      int   budget;
      logic took;

      tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      chk("rst.valid", 32'(val_a), 0);
      chk("rst.acc",   32'(acc_a), 0);
      chk("rst.cnt",   32'(cnt_a), 0);
      chk("rst.ovf",   32'(ovf_a), 0);

      // Basic frame
      tick(0, 0, 1, 10, 0); chk("basic.cnt1", 32'(cnt_a), 1);
      tick(0, 0, 1, 20, 0); chk("basic.cnt2", 32'(cnt_a), 2);
      tick(0, 0, 1, 30, 0); chk("basic.cnt3", 32'(cnt_a), 3);
      tick(0, 0, 1, 40, 0); chk("basic.cnt0", 32'(cnt_a), 0);
      chk("basic.valid", 32'(val_a), 1);
      chk("basic.acc",   32'(acc_a), 100);
      chk("basic.ovf",   32'(ovf_a), 0);
      tick(0, 0, 0, 0, 1);
      chk("basic.acc_after", 32'(acc_a), 0);
      chk("basic.ready_after", 32'(rdy_a), 1);

      // Max values and narrow-accumulator wrap
      frame4(255, 255, 255, 255);
      chk("max.acc", 32'(acc_a), 1020);
      chk("max.ovf", 32'(ovf_a), 0);
      chk("max.b_acc", 32'(acc_b), 252);
      chk("max.b_ovf", 32'(ovf_b), 1);
      tick(0, 0, 0, 0, 1);
      frame4(200, 100, 0, 0);
      chk("wrap.b_acc", 32'(acc_b), 44);
      chk("wrap.b_ovf", 32'(ovf_b), 1);
      chk("wrap.a_acc", 32'(acc_a), 300);
      tick(0, 0, 0, 0, 1);

      // Backpressure: offered 99 must never be consumed
      frame4(1, 2, 3, 4);
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, 1, 99, 0);
         chk("bp.acc", 32'(acc_a), 10);
         chk("bp.ready", 32'(rdy_a), 0);
      end
      tick(0, 0, 0, 0, 1);
      chk("bp.released", 32'(val_a), 0);

      // Clear mid-frame drops the coincident word
      tick(0, 0, 1, 5, 0);
      tick(0, 0, 1, 6, 0);
      tick(0, 1, 1, 7, 0);
      chk("clr.acc", 32'(acc_a), 0);
      chk("clr.cnt", 32'(cnt_a), 0);
      frame4(1, 1, 1, 1);
      chk("clr.total", 32'(acc_a), 4);
      tick(0, 0, 0, 0, 1);

      // Reset while holding a total, then reset together with clear
      for (int j = 0; j < 2; j++) begin
         frame4(10, 20, 30, 40);
         chk("rsthold.acc", 32'(acc_a), 100);
         rst = 1'b1; clr = (j == 1); vld = 1'b0; rdy = 1'b0;
         #1;
         chk("rsthold.ready_in_rst", 32'(rdy_a), 0);
         @(posedge clk);
         #1;
         chk("rsthold.ready_in_rst2", 32'(rdy_a), 0);
         chk("rsthold.valid", 32'(val_a), 0);
         chk("rsthold.acc0",  32'(acc_a), 0);
         chk("rsthold.ovf",   32'(ovf_a), 0);
         tick(0, 0, 0, 0, 0);
      end

      // Back-to-back frames with valid and ready held high
      ntot = 0;
      k = 1;
      budget = 40;
      while (k <= 8 && budget > 0) begin
         vld = 1'b1; rdy = 1'b1; data = 8'(k); rst = 1'b0; clr = 1'b0;
         took = rdy_a;
         @(posedge clk);
         #1;
         if (took) k++;
         if (val_a && ntot < 2) begin
            totals[ntot] = int'(acc_a);
            ntot++;
         end
         budget--;
      end
      vld = 1'b0;
      @(posedge clk);
      #1;
      if (val_a && ntot < 2) begin
         totals[ntot] = int'(acc_a);
         ntot++;
      end
      chk("b2b.words_taken", 32'(k), 9);
      chk("b2b.frames", 32'(ntot), 2);
      if (ntot == 2) begin
         chk("b2b.total1", 32'(totals[0]), 10);
         chk("b2b.total2", 32'(totals[1]), 26);
      end
      tick(0, 0, 0, 0, 1);
      tick(0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/adder_accum.md
Name: adder_accum

Overview:
- Sequential accumulation stage placed directly downstream of the BW_DATA-wide adder datapath. It consumes a stream of BW_DATA-bit sum words and adds each one into a wider running accumulator, so carries are never lost.
- A frame is NUM_OPS consecutive accepted words. At the end of each frame the block presents the frame total on a valid/ready output and holds it until the consumer takes it.

Parameters:
- BW_DATA, 8, width of each input word
- NUM_OPS, 4, number of words per frame (>=2)
- BW_ACC, 10, accumulator/output width (>=BW_DATA); carry-out beyond BW_ACC sets the overflow flag
- BW_CNT, 2, operand counter width; must satisfy 2^BW_CNT >= NUM_OPS

Ports:
- i_clk, input, 1, clock, rising-edge
- i_rst, input, 1, reset, synchronous, active-high
- i_clr, input, 1, synchronous frame abort/clear
- i_valid, input, 1, input word valid
- o_ready, output, 1, block can accept a word this cycle
- i_data, input, BW_DATA, input word (unsigned)
- o_valid, output, 1, frame total valid
- i_ready, input, 1, consumer accepts total
- o_acc, output, BW_ACC, accumulator value (frame total when o_valid=1)
- o_ovf, output, 1, frame overflow flag (sticky within frame)
- o_cnt, output, BW_CNT, number of words accepted in current frame

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state updates on the rising edge of i_clk.
- Reset (i_rst=1 at an edge):
  - state=ACC; acc=0, cnt=0, ovf=0, o_valid=0.
  - o_ready is forced to 0 combinationally while i_rst=1.
  - Reset overrides every other input in any state.
- State ACC:
  - o_ready=1, o_valid=0.
  - Accept happens when i_valid && o_ready.
  - On accept: {carry, acc} <= acc + zero-extended i_data; ovf <= ovf | carry.
  - On accept with cnt < NUM_OPS-1: cnt <= cnt+1, stay in ACC.
  - On accept with cnt == NUM_OPS-1: cnt <= 0, go to HOLD.
  - i_valid=0: no change.
- State HOLD:
  - o_valid=1, o_ready=0; o_acc and o_ovf are frozen.
  - i_valid is ignored and no word is consumed.
  - On i_ready=1: acc <= 0, ovf <= 0, go to ACC. o_ready is 1 the following cycle.
- Latency:
  - o_valid rises in the cycle after the edge that accepted the last word of the frame.
  - Minimum frame period is NUM_OPS+1 cycles, because HOLD lasts at least 1 cycle.
- i_clr:
  - In ACC: acc, cnt and ovf go to 0. If a word is offered in the same cycle it is dropped (clear wins).
  - In HOLD: the pending total is discarded (acc=0, ovf=0) and the block goes to ACC whatever i_ready is.
  - i_rst takes priority over i_clr.
- Arithmetic:
  - Unsigned, modulo 2^BW_ACC.
  - o_ovf is set at the first wrap in a frame and stays set until the total is taken, i_clr, or i_rst.
- Outputs:
  - o_acc = acc register in all states; in ACC it shows the running partial sum.
  - o_cnt = cnt register.
- Forbidden/illegal cases:
  - No combinational path from i_valid to o_ready, or from i_ready to o_valid.
  - Parameter sets with 2^BW_CNT < NUM_OPS are illegal and are caught with an elaboration check.

Test Plan:
- Basic frame, defaults: reset, then words 10, 20, 30, 40 on consecutive cycles -> o_cnt steps 1, 2, 3, 0. Next cycle o_valid=1, o_acc=100, o_ovf=0; with i_ready=1 -> o_acc=0 and o_ready=1 one cycle later.
- Max values: four words of 255 -> o_acc=1020 (0x3FC), o_ovf=0. Override BW_ACC=8 with words 200, 100, 0, 0 -> o_acc=44, o_ovf=1.
- Backpressure: complete a frame (1, 2, 3, 4) with i_ready=0 for 3 cycles while i_valid=1 and i_data=99 -> o_acc holds 10, o_ready=0, 99 is never accumulated. Then i_ready=1 -> ACC.
- Clear mid-frame: accept 5, 6, then i_clr=1 with i_valid=1 and i_data=7 -> acc=0, cnt=0, 7 dropped. Then 1, 1, 1, 1 -> o_acc=4.
- Reset mid-operation:
  - i_rst=1 while in HOLD with o_acc=100 -> next cycle o_valid=0, o_acc=0, o_ovf=0; o_ready=0 throughout the reset cycle.
  - i_rst and i_clr asserted together -> same result.
- Back-to-back frames: i_valid held high, i_ready held high, data 1..8 -> totals 10 then 26, one HOLD cycle between frames, no word lost or duplicated.
